// File: rtl/vga_scan_engine_if.sv
// Pixel-fetch and DAC-side signal bundle for vga_scan_engine.
// master = scan engine, slave = pixel source / DAC pins.
interface vga_scan_engine_if #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int CW = 4
);
  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic          vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_SYNC;
  logic [CW-1:0] vga_R, vga_G, vga_B;

  modport master (
    output pix_req, pix_x, pix_y,
    input  pix_r, pix_g, pix_b,
    output vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_SYNC, vga_R, vga_G, vga_B
  );
  modport slave (
    input  pix_req, pix_x, pix_y,
    output pix_r, pix_g, pix_b,
    input  vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_SYNC, vga_R, vga_G, vga_B
  );
endinterface

// File: rtl/vga_scan_engine.sv
// Parametrised VGA timing generator with latency-matched pixel fetch and clean frame-boundary stop.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds tp_sel input).
module vga_scan_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 4,
  parameter int PIPE     = 2,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic tp_sel,
`endif
  output logic frame_start,
  output logic busy,
  vga_scan_engine_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  // One tap of the timing delay line; tap_pipe[0] is the lead cycle itself.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
`ifdef VGA_TEST_PATTERN_EN
    logic [XW-1:0] x;
`endif
  } tap_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   h, h_nxt, px;
  logic [YW-1:0]   v, v_nxt, py;
  logic            at_end;
  tap_t            lead_nxt, o;
  tap_t [PIPE:0]   tap_pipe;
  logic            hs_q, vs_q, blank_q, fs_q;
  logic [CW-1:0]   r_q, g_q, b_q, r_nxt, g_nxt, b_nxt;

  assign at_end = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP:    if (en) state_nxt = RUN;
               else if (at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters restart from 0 on IDLE->RUN and park at 0 while idle.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (state != IDLE && state_nxt != IDLE) begin
      if (h == H_LAST) begin
        v_nxt = (v == V_LAST) ? '0 : v + YW'(1);
      end else begin
        h_nxt = h + XW'(1);
        v_nxt = v;
      end
    end
  end

  always_comb begin
    lead_nxt = '0;
    if (state_nxt != IDLE) begin
      lead_nxt.act = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      lead_nxt.hs  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      lead_nxt.vs  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
      lead_nxt.fs  = (h_nxt == '0) && (v_nxt == '0);
    end
`ifdef VGA_TEST_PATTERN_EN
    lead_nxt.x = h_nxt;
`endif
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      h        <= '0;
      v        <= '0;
      px       <= '0;
      py       <= '0;
      tap_pipe <= '0;
    end else begin
      h <= h_nxt;
      v <= v_nxt;
      if (lead_nxt.act) begin
        px <= h_nxt;
        py <= v_nxt;
      end
      for (int k = PIPE; k > 0; k--) tap_pipe[k] <= tap_pipe[k-1];
      tap_pipe[0] <= lead_nxt;
    end

  // Tap PIPE lines up with the cycle in which the source presents the data.
  assign o = tap_pipe[PIPE];

`ifdef VGA_TEST_PATTERN_EN
  logic            tp_lat, tp_use;
  logic [XW+2:0]   bar_full;
  logic [2:0]      bar;

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) tp_lat <= 1'b0;
    else if (o.fs)      tp_lat <= tp_sel;

  assign tp_use   = o.fs ? tp_sel : tp_lat;
  assign bar_full = {o.x, 3'b000} / (XW+3)'(H_ACTIVE);
  assign bar      = bar_full[2:0];
`endif

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (o.act) begin
      r_nxt = bus.pix_r;
      g_nxt = bus.pix_g;
      b_nxt = bus.pix_b;
`ifdef VGA_TEST_PATTERN_EN
      if (tp_use) begin
        r_nxt = {CW{bar[2]}};
        g_nxt = {CW{bar[1]}};
        b_nxt = {CW{bar[0]}};
      end
`endif
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= o.hs ? HS_ON : ~HS_ON;
      vs_q    <= o.vs ? VS_ON : ~VS_ON;
      blank_q <= o.act;
      fs_q    <= o.fs;
      r_q     <= r_nxt;
      g_q     <= g_nxt;
      b_q     <= b_nxt;
    end

  assign busy          = (state != IDLE);
  assign frame_start   = fs_q;
  assign bus.pix_req   = tap_pipe[0].act;
  assign bus.pix_x     = px;
  assign bus.pix_y     = py;
  assign bus.vga_CLK   = clk_clk;
  assign bus.vga_HS    = hs_q;
  assign bus.vga_VS    = vs_q;
  assign bus.vga_BLANK = blank_q;
  assign bus.vga_SYNC  = 1'b0;
  assign bus.vga_R     = r_q;
  assign bus.vga_G     = g_q;
  assign bus.vga_B     = b_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Randomised bench for vga_scan_engine on a shrunken raster, checked every cycle
// against a linear-position frame model, plus directed literal checks.
module tb_vga_scan_engine;
  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VSY = 2, VB = 2;
  localparam int P = 2, CW = 4, XW = 11, YW = 10;
  localparam int HT = HA + HF + HSY + HB;   // 24
  localparam int VT = VA + VF + VSY + VB;   // 11
  localparam int FT = HT * VT;              // 264

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic frame_start, busy;
  vga_scan_engine_if #(.XW(XW), .YW(YW), .CW(CW)) bus();

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .CW(CW), .PIPE(P), .XW(XW), .YW(YW)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .tp_sel(1'b0),
`endif
    .frame_start(frame_start), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit act, hs, vs, fs;
    int x, y;
  } lead_t;

  int tests = 0, fails = 0;
  int mode = 0;     // 0 off, 1 scanning with en, 2 finishing frame
  int pos  = 0;     // linear position within frame
  int last_x = 0, last_y = 0;
  lead_t ld [0:P+1];
  logic [3*CW-1:0] src [0:P];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [3*CW-1:0] pix_of(input int x, input int y);
    logic [CW-1:0] r, g, b;
    r = CW'(x);
    g = CW'(x + 3 * y);
    b = CW'(x ^ (5 * y));
    return {r, g, b};
  endfunction

  function automatic lead_t lead_of(input int md, input int p);
    lead_t l;
    int x, y;
    x = p % HT;
    y = p / HT;
    l.x = x;
    l.y = y;
    l.act = (md != 0) && x < HA && y < VA;
    l.hs  = (md != 0) && x >= HA + HF && x < HA + HF + HSY;
    l.vs  = (md != 0) && y >= VA + VF && y < VA + VF + VSY;
    l.fs  = (md != 0) && p == 0;
    return l;
  endfunction

  // Compare, then act as pixel source, then advance the model by one clock.
  always @(negedge clk) begin
    lead_t e;
    logic [3*CW-1:0] ep;
    if (!rst_n) begin
      mode = 0; pos = 0; last_x = 0; last_y = 0;
      for (int k = 0; k <= P + 1; k++) ld[k] = lead_of(0, 0);
    end
    e  = ld[P+1];
    ep = e.act ? pix_of(e.x, e.y) : '0;
    chk("pix_req", bus.pix_req, ld[0].act);
    chk("pix_x", bus.pix_x, last_x);
    chk("pix_y", bus.pix_y, last_y);
    chk("busy", busy, mode != 0);
    chk("vga_HS", bus.vga_HS, e.hs ? 0 : 1);
    chk("vga_VS", bus.vga_VS, e.vs ? 0 : 1);
    chk("vga_BLANK", bus.vga_BLANK, e.act);
    chk("vga_SYNC", bus.vga_SYNC, 0);
    chk("frame_start", frame_start, e.fs);
    chk("vga_RGB", {bus.vga_R, bus.vga_G, bus.vga_B}, ep);

    for (int k = P; k > 0; k--) src[k] = src[k-1];
    src[0] = bus.pix_req ? pix_of(int'(bus.pix_x), int'(bus.pix_y)) : (3*CW)'($urandom);
    {bus.pix_r, bus.pix_g, bus.pix_b} = src[P];

    if (rst_n) begin
      if (mode == 0) begin
        if (en) begin mode = 1; pos = 0; end
      end else if (mode == 1) begin
        if (!en) mode = 2;
        pos = (pos + 1) % FT;
      end else begin
        if (en) begin mode = 1; pos = (pos + 1) % FT; end
        else if (pos == FT - 1) begin mode = 0; pos = 0; end
        else pos = pos + 1;
      end
      for (int k = P + 1; k > 0; k--) ld[k] = ld[k-1];
      ld[0] = lead_of(mode, pos);
      if (ld[0].act) begin last_x = ld[0].x; last_y = ld[0].y; end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, nhs, nvs, nblank, nfs, fblank, ffs, nbusy;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_HS", bus.vga_HS, 1);
    chk("idle_VS", bus.vga_VS, 1);
    chk("idle_BLANK", bus.vga_BLANK, 0);
    chk("idle_busy", busy, 0);
    chk("vga_CLK_high", bus.vga_CLK, 1);

    // First frame from enable: pin the model with hand-computed counts.
    en = 1'b1;
    nreq = 0; nhs = 0; nvs = 0; nblank = 0; nfs = 0; fblank = -1; ffs = -1;
    for (int k = 0; k < FT; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        chk("first_req", bus.pix_req, 1);
        chk("first_x", bus.pix_x, 0);
        chk("first_y", bus.pix_y, 0);
      end
      nreq += bus.pix_req;
      nhs  += !bus.vga_HS;
      nvs  += !bus.vga_VS;
      nblank += bus.vga_BLANK;
      nfs  += frame_start;
      if (bus.vga_BLANK && fblank < 0) fblank = k;
      if (frame_start && ffs < 0) ffs = k;
    end
    chk("req_per_frame", nreq, 96);
    chk("hs_low_clocks", nhs, 33);
    chk("vs_low_clocks", nvs, 48);
    chk("blank_high_clocks", nblank, 96);
    chk("frame_starts", nfs, 1);
    chk("blank_latency", fblank, 3);
    chk("fs_latency", ffs, 3);

    // Drop en at the end of line 2 of frame 2: lines 3..10 still complete.
    repeat (72) @(posedge clk);
    #1 en = 1'b0;
    nbusy = 0; nreq = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
      nbusy++;
      nreq += bus.pix_req;
    end
    chk("stop_busy_clocks", nbusy, 192);
    chk("stop_reqs", nreq, 48);
    nreq = 0;
    repeat (50) begin @(posedge clk); #1; nreq += bus.pix_req; end
    chk("idle_reqs", nreq, 0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", bus.pix_req, 1);

    // Mid-frame asynchronous reset.
    repeat (137) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.pix_req, 0);
    chk("rst_x", bus.pix_x, 0);
    chk("rst_HS", bus.vga_HS, 1);
    chk("rst_VS", bus.vga_VS, 1);
    chk("rst_BLANK", bus.vga_BLANK, 0);
    chk("rst_R", bus.vga_R, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Random en toggling with occasional resets; the negedge process checks every cycle.
    for (int c = 0; c < 15000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 3999) == 0) begin
        #1 rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
